// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 controller: opcodes, instruction
// classes, FSM states, and the imm_sel / pc_sel / wb_sel select codes.
package rv32_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } ctrl_state_e;

  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_R      = 4'd1,
    CLS_IALU   = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9
  } op_class_e;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode decoder: maps instruction[6:0] to an instruction class,
// the immediate format for that class, and a legal-opcode flag.
module ctrl_opcode_decode
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [3:0] op_class,
  output logic [2:0] imm_sel,
  output logic       legal
);

  always_comb begin
    op_class = CLS_NONE;
    imm_sel  = IMM_NONE;
    legal    = 1'b1;
    case (opcode)
      OPC_R:      begin op_class = CLS_R;      imm_sel = IMM_NONE; end
      OPC_IALU:   begin op_class = CLS_IALU;   imm_sel = IMM_I;    end
      OPC_LOAD:   begin op_class = CLS_LOAD;   imm_sel = IMM_I;    end
      OPC_STORE:  begin op_class = CLS_STORE;  imm_sel = IMM_S;    end
      OPC_BRANCH: begin op_class = CLS_BRANCH; imm_sel = IMM_B;    end
      OPC_JAL:    begin op_class = CLS_JAL;    imm_sel = IMM_J;    end
      OPC_JALR:   begin op_class = CLS_JALR;   imm_sel = IMM_I;    end
      OPC_LUI:    begin op_class = CLS_LUI;    imm_sel = IMM_U;    end
      OPC_AUIPC:  begin op_class = CLS_AUIPC;  imm_sel = IMM_U;    end
      default:    begin op_class = CLS_NONE;   imm_sel = IMM_NONE; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with a retired
// instruction counter. Define CTRL_ILLEGAL_TRAP_EN to trap on unsupported opcodes.
module multicycle_controller
  import rv32_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  input  logic             instr_valid,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             fetch_req,
  output logic             ir_write,
  output logic [2:0]       imm_sel,
  output logic             alu_src_b_imm,
  output logic             alu_src_a_pc,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instr_retired
);

  ctrl_state_e      state_q, state_d;
  op_class_e        cls_q, cls_d;
  logic [2:0]       imm_q, imm_d;
  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire_s;

  logic [3:0]       dec_cls_raw_s;
  op_class_e        dec_cls_s;
  logic [2:0]       dec_imm_s;
  logic             dec_legal_s;
  logic             unused_instr_s;

  ctrl_opcode_decode u_dec (
    .opcode   (instruction[6:0]),
    .op_class (dec_cls_raw_s),
    .imm_sel  (dec_imm_s),
    .legal    (dec_legal_s)
  );

  assign dec_cls_s      = op_class_e'(dec_cls_raw_s);
  assign unused_instr_s = ^instruction[31:7];

  // run_q holds every strobe low until the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= CLS_NONE;
      imm_q   <= IMM_NONE;
      run_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      imm_q   <= imm_d;
      run_q   <= 1'b1;
      if (retire_s) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= cnt_q;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    imm_d         = imm_q;
    retire_s      = 1'b0;
    fetch_req     = 1'b0;
    ir_write      = 1'b0;
    imm_sel       = imm_q;
    alu_src_b_imm = 1'b0;
    alu_src_a_pc  = 1'b0;
    pc_write      = 1'b0;
    pc_sel        = PC_PLUS4;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = WB_ALU;

    case (state_q)
      S_FETCH: begin
        imm_sel   = IMM_NONE;
        imm_d     = IMM_NONE;
        fetch_req = run_q;
        if (run_q && instr_valid) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          state_d  = S_FETCH;
        end
      end

      // The IR was loaded on the FETCH edge, so the decoder sees the new word here
      S_DECODE: begin
        imm_sel = dec_imm_s;
        imm_d   = dec_imm_s;
        cls_d   = dec_cls_s;
        if (dec_cls_s == CLS_BRANCH) begin
          alu_src_a_pc  = 1'b1;
          alu_src_b_imm = 1'b1;
        end else begin
          alu_src_a_pc  = 1'b0;
          alu_src_b_imm = 1'b0;
        end
        if (dec_legal_s) begin
          state_d = S_EXEC;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d  = S_FETCH;
          retire_s = 1'b1;
`endif
        end
      end

      S_EXEC: begin
        case (cls_q)
          CLS_R:     state_d = S_WB;
          CLS_IALU:  begin alu_src_b_imm = 1'b1; state_d = S_WB;  end
          CLS_LOAD:  begin alu_src_b_imm = 1'b1; state_d = S_MEM; end
          CLS_STORE: begin alu_src_b_imm = 1'b1; state_d = S_MEM; end
          CLS_BRANCH: begin
            pc_write = branch_taken;
            pc_sel   = PC_TARGET;
            state_d  = S_FETCH;
            retire_s = 1'b1;
          end
          CLS_JAL: begin
            alu_src_a_pc  = 1'b1;
            alu_src_b_imm = 1'b1;
            pc_write      = 1'b1;
            pc_sel        = PC_TARGET;
            state_d       = S_WB;
          end
          CLS_JALR: begin
            alu_src_b_imm = 1'b1;
            pc_write      = 1'b1;
            pc_sel        = PC_JALR;
            state_d       = S_WB;
          end
          CLS_LUI:   state_d = S_WB;
          CLS_AUIPC: begin alu_src_a_pc = 1'b1; alu_src_b_imm = 1'b1; state_d = S_WB; end
          default: begin
            state_d  = S_FETCH;
            retire_s = 1'b1;
          end
        endcase
      end

      S_MEM: begin
        if (cls_q == CLS_LOAD) begin
          mem_read = 1'b1;
          state_d  = mem_ready ? S_WB : S_MEM;
        end else if (cls_q == CLS_STORE) begin
          mem_write = 1'b1;
          if (mem_ready) begin
            state_d  = S_FETCH;
            retire_s = 1'b1;
          end else begin
            state_d  = S_MEM;
          end
        end else begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        case (cls_q)
          CLS_LOAD: wb_sel = WB_MEM;
          CLS_JAL:  wb_sel = WB_PC4;
          CLS_JALR: wb_sel = WB_PC4;
          CLS_LUI:  wb_sel = WB_IMM;
          default:  wb_sel = WB_ALU;
        endcase
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end

      S_TRAP: begin
        imm_sel = IMM_NONE;
        state_d = S_TRAP;
      end

      default: begin
        imm_sel = IMM_NONE;
        state_d = S_FETCH;
      end
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == S_TRAP);
`else
  assign illegal_instr = 1'b0;
`endif

  assign instr_retired = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller: per-cycle strobe
// checks for each instruction class, NOP/trap handling and mid-MEM reset.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic        instr_valid, mem_ready, branch_taken;
  logic        fetch_req, ir_write, alu_src_b_imm, alu_src_a_pc, pc_write;
  logic [2:0]  imm_sel;
  logic [1:0]  pc_sel, wb_sel;
  logic        mem_read, mem_write, reg_write, illegal_instr;
  logic [31:0] instr_retired;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .branch_taken(branch_taken), .fetch_req(fetch_req),
    .ir_write(ir_write), .imm_sel(imm_sel), .alu_src_b_imm(alu_src_b_imm),
    .alu_src_a_pc(alu_src_a_pc), .pc_write(pc_write), .pc_sel(pc_sel),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .wb_sel(wb_sel), .illegal_instr(illegal_instr), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {fetch_req, ir_write, imm_sel, pc_write, pc_sel, mem_read, mem_write, reg_write, wb_sel}
  function automatic logic [12:0] pk(input logic f, input logic irw, input logic [2:0] imm,
                                     input logic pcw, input logic [1:0] pcs, input logic mr,
                                     input logic mw, input logic rw, input logic [1:0] wb);
    return {f, irw, imm, pcw, pcs, mr, mw, rw, wb};
  endfunction

  wire [12:0] obs_pk = {fetch_req, ir_write, imm_sel, pc_write, pc_sel,
                        mem_read, mem_write, reg_write, wb_sel};

  task automatic cyc(input string tag, input logic [12:0] exp);
    #1;
    check(tag, obs_pk, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] ins);
    instruction = ins;
    instr_valid = 1'b1;
    cyc(tag, pk(1'b1, 1'b1, 3'd7, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    instr_valid = 1'b0;
  endtask

  task automatic idle_fetch(input string tag);
    #1;
    check(tag, obs_pk, pk(1'b1, 1'b0, 3'd7, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    check({tag, "_cnt"}, instr_retired, exp_cnt);
  endtask

  initial begin
    rst_n = 1'b0; instruction = 32'h0; instr_valid = 1'b0;
    mem_ready = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", obs_pk, pk(1'b0, 1'b0, 3'd7, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    check("reset_cnt", instr_retired, 32'd0);
    check("reset_illegal", illegal_instr, 1'b0);
    rst_n = 1'b1;
    #1;
    check("release_pre_edge", fetch_req, 1'b0);
    @(posedge clk);
    #1;
    check("release_fetch_req", fetch_req, 1'b1);

    // ADDI: 4 cycles
    fetch("addi_f", 32'h00500093);
    cyc("addi_d", pk(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    check("addi_e_bimm", alu_src_b_imm, 1'b1);
    cyc("addi_e", pk(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    check("addi_wb_cnt_before", instr_retired, 32'd0);
    cyc("addi_wb", pk(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0));
    exp_cnt++;
    idle_fetch("addi_done");

    // LW with three mem_ready wait cycles: 8 cycles
    fetch("lw_f", 32'h00402103);
    cyc("lw_d", pk(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    cyc("lw_e", pk(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("lw_mem_wait", pk(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
    mem_ready = 1'b1;
    cyc("lw_mem_done", pk(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0));
    mem_ready = 1'b0;
    cyc("lw_wb", pk(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1));
    exp_cnt++;
    idle_fetch("lw_done");

    // SW with one wait cycle, no reg_write
    fetch("sw_f", 32'h00312223);
    cyc("sw_d", pk(1'b0, 1'b0, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    cyc("sw_e", pk(1'b0, 1'b0, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    cyc("sw_mem_wait", pk(1'b0, 1'b0, 3'd1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0));
    mem_ready = 1'b1;
    cyc("sw_mem_done", pk(1'b0, 1'b0, 3'd1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0));
    mem_ready = 1'b0;
    exp_cnt++;
    idle_fetch("sw_done");

    // BEQ taken and not taken: 3 cycles each
    fetch("beq_t_f", 32'h00208063);
    cyc("beq_t_d", pk(1'b0, 1'b0, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    branch_taken = 1'b1;
    cyc("beq_t_e", pk(1'b0, 1'b0, 3'd2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0));
    branch_taken = 1'b0;
    exp_cnt++;
    idle_fetch("beq_t_done");

    fetch("beq_n_f", 32'h00208063);
    cyc("beq_n_d", pk(1'b0, 1'b0, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    cyc("beq_n_e", pk(1'b0, 1'b0, 3'd2, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0));
    exp_cnt++;
    idle_fetch("beq_n_done");

    // JAL and JALR
    fetch("jal_f", 32'h0040006F);
    cyc("jal_d", pk(1'b0, 1'b0, 3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    check("jal_e_apc", alu_src_a_pc, 1'b1);
    cyc("jal_e", pk(1'b0, 1'b0, 3'd4, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0));
    cyc("jal_wb", pk(1'b0, 1'b0, 3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2));
    exp_cnt++;
    idle_fetch("jal_done");

    fetch("jalr_f", 32'h00500067);
    cyc("jalr_d", pk(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    cyc("jalr_e", pk(1'b0, 1'b0, 3'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0));
    cyc("jalr_wb", pk(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2));
    exp_cnt++;
    idle_fetch("jalr_done");

    // LUI writes back the immediate
    fetch("lui_f", 32'h123450B7);
    cyc("lui_d", pk(1'b0, 1'b0, 3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    cyc("lui_e", pk(1'b0, 1'b0, 3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    cyc("lui_wb", pk(1'b0, 1'b0, 3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd3));
    exp_cnt++;
    idle_fetch("lui_done");

    // Unsupported opcode
    fetch("ill_f", 32'h0000007F);
    cyc("ill_d", pk(1'b0, 1'b0, 3'd7, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      check("trap_illegal", illegal_instr, 1'b1);
      cyc("trap_out", pk(1'b0, 1'b0, 3'd7, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    end
    check("trap_cnt", instr_retired, exp_cnt);
    rst_n = 1'b0;
    #1;
    check("trap_reset_illegal", illegal_instr, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt = 0;
`else
    exp_cnt++;
    check("ill_nop_illegal", illegal_instr, 1'b0);
`endif
    idle_fetch("ill_done");

    // Reset pulse while a load sits in MEM
    fetch("rst_lw_f", 32'h00402103);
    cyc("rst_lw_d", pk(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    cyc("rst_lw_e", pk(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    #1;
    check("rst_lw_mem", mem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out", obs_pk, pk(1'b0, 1'b0, 3'd7, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    check("rst_mid_cnt", instr_retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    exp_cnt = 0;
    idle_fetch("rst_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instruction  input  32  instruction register contents; decoded in DECODE.
REQ-005 instr_valid  input  1  fetch memory has the instruction word available.
REQ-006 mem_ready  input  1  data memory completes the current access.
REQ-007 branch_taken  input  1  ALU branch-condition result, sampled in EXEC.
REQ-008 fetch_req  output  1  instruction fetch request.
REQ-009 ir_write  output  1  load the instruction register.
REQ-010 imm_sel  output  3  immediate-generator format: I=0, S=1, B=2, U=3, J=4, NONE=7.
REQ-011 alu_src_b_imm  output  1  ALU operand B selects the immediate.
REQ-012 alu_src_a_pc  output  1  ALU operand A selects the PC (AUIPC, JAL, branch target).
REQ-013 pc_write  output  1  update the PC.
REQ-014 pc_sel  output  2  next PC source: 0=pc+4, 1=branch/JAL target, 2=JALR target (LSB cleared).
REQ-015 mem_read, mem_write  output  1 each  data memory strobes.
REQ-016 reg_write  output  1  register-file write enable.
REQ-017 wb_sel  output  2  write-back source: 0=ALU, 1=memory, 2=pc+4, 3=immediate (LUI).
REQ-018 illegal_instr  output  1  unsupported opcode detected.
REQ-019 instr_retired  output  CNT_W  count of completed instructions.

Function
REQ-020 States SHALL be FETCH, DECODE, EXEC, MEM, WB and TRAP; reset state SHALL be FETCH.
REQ-021 FETCH: fetch_req=1; with instr_valid=1, ir_write=1 and pc_write=1 (pc_sel=0), then go to DECODE; otherwise stay.
REQ-022 DECODE: one cycle; latch opcode class (R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC) from instruction[6:0] and drive imm_sel.
REQ-023 imm_sel SHALL be held from DECODE until return to FETCH; it SHALL be NONE in FETCH.
REQ-024 EXEC: R and I-ALU go to WB; LOAD and STORE go to MEM; BRANCH goes to FETCH with pc_write=branch_taken and pc_sel=1; JAL and JALR assert pc_write (pc_sel 1 and 2 respectively) and go to WB; LUI and AUIPC go to WB.
REQ-025 MEM: hold mem_read (LOAD) or mem_write (STORE) until mem_ready=1. On that cycle LOAD goes to WB and STORE goes to FETCH.
REQ-026 WB: reg_write=1 for one cycle with wb_sel per class, then go to FETCH.
REQ-027 Minimum latency in cycles: ALU, JAL, JALR, LUI, AUIPC = 4; BRANCH = 3; STORE = 4; LOAD = 5. Each instr_valid or mem_ready wait cycle adds one.
REQ-028 mem_read and mem_write SHALL never be asserted together, and SHALL be 0 outside MEM.
REQ-029 instr_retired SHALL increment by one on every transition into FETCH from EXEC, MEM or WB, and SHALL wrap modulo 2^CNT_W.
REQ-030 Outputs SHALL depend on state and the latched class only, except ir_write and fetch-stage pc_write, which depend on instr_valid; branch pc_write, which depends on branch_taken; and MEM completion, which depends on mem_ready.

Reset
REQ-031 rst_n low SHALL force FETCH immediately, including mid-instruction (for example while in MEM).
REQ-032 During reset: instr_retired=0, illegal_instr=0, imm_sel=NONE, and all strobes (fetch_req, ir_write, pc_write, mem_read, mem_write, reg_write) = 0.
REQ-033 After rst_n deasserts, fetch_req SHALL assert on the first clock edge.

Configuration
REQ-034 Macro CTRL_ILLEGAL_TRAP_EN: when defined, an unsupported opcode in DECODE SHALL enter TRAP.
- In TRAP: illegal_instr=1 (sticky), all strobes 0, and the block stays there until reset.
REQ-035 When CTRL_ILLEGAL_TRAP_EN is undefined, an unsupported opcode SHALL be a NOP.
- The controller goes DECODE -> FETCH and increments instr_retired.
- illegal_instr is tied to 0.

Structure
REQ-036 Shared package rv32_ctrl_pkg SHALL hold the opcode constants, the imm_sel encodings, the state encodings, and the pc_sel and wb_sel encodings.
REQ-037 Combinational sub-module ctrl_opcode_decode SHALL map an opcode to its class, imm_sel and a legal flag; the FSM instantiates it.

Verification
REQ-038 ADDI 0x00500093, instr_valid=1 -> states FETCH, DECODE, EXEC, WB; imm_sel=0; reg_write=1, wb_sel=0 in cycle 4; instr_retired goes 0 -> 1.
REQ-039 LW 0x00402103, mem_ready low for 3 cycles -> mem_read held 4 cycles; WB with wb_sel=1; total 8 cycles.
REQ-040 SW 0x00312223 -> imm_sel=1, mem_write=1 until mem_ready, no reg_write; BEQ 0x00208063 with branch_taken=1 -> pc_write=1 and pc_sel=1 in EXEC; with branch_taken=0 -> pc_write=0; both take 3 cycles.
REQ-041 JAL 0x0040006F -> imm_sel=4, pc_sel=1 in EXEC, then wb_sel=2 in WB; JALR 0x00500067 -> pc_sel=2.
REQ-042 Opcode 0x0000007F -> with the macro: TRAP, illegal_instr=1, stays until reset; without it: back to FETCH after DECODE, counter incremented.
REQ-043 rst_n pulsed low while in MEM -> mem_read drops immediately; FETCH on release; instr_retired=0.
